// File: rtl/router_pkg.sv
// Shared types and default sizing for the serial router receive port.
// Holds the receive FSM state encoding and the FIFO entry layout.
// The entry struct uses the default widths; parametrised users build their own view.
package router_pkg;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_PAD_CYC = 5;

    // One shared counter walks address bits, pad cycles and payload bits.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_PAD  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  last;
    } rx_entry_t;

    // Flattened FIFO entry width for a given address/data sizing.
    function automatic int entry_w(input int aw, input int dw);
        return aw + dw + 1;
    endfunction

endpackage

// File: rtl/router_rx_fifo.sv
// Purpose: first-word-fall-through FIFO with full/empty/occupancy outputs.
// Latency: a word pushed at edge N is on o_dat after edge N when the FIFO was empty.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module router_rx_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_rd;
    logic             w_wr;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_dat   = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written on accepted pushes only, contents need no reset.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
            else if (!w_wr && w_rd) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/router_rx_port.sv
// Purpose: deserialises framed packets (addr, pad, payload) into words queued in a FWFT FIFO.
// Latency: a completed word is on out_* one cycle after its final bit is sampled.
// Backpressure: out_valid/out_ready pop; busy_n low while full; words arriving when full are dropped (err_ovf).
// Optional: define ROUTER_RX_ERR_CNT_EN to add the saturating 8-bit err_cnt output.
module router_rx_port
    import router_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PAD_CYC = DEF_PAD_CYC
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              din,
    input  logic              frame_n,
    input  logic              valid_n,
    output logic              busy_n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              err_partial,
    output logic              err_abort,
    output logic              err_ovf
`ifdef ROUTER_RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int EW = entry_w(ADDR_W, DATA_W);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'((PAD_CYC > 0) ? PAD_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    // With no pad cycles the address phase hands straight over to payload.
    localparam state_t AFTER_ADDR = (PAD_CYC > 0) ? ST_PAD : ST_DATA;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } entry_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_addr_set;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_word_nxt;
    logic [DATA_W-1:0] w_word_set;
    logic              w_push;
    logic              w_last;
    logic              w_partial;
    logic              w_abort;
    logic              r_err_partial;
    logic              r_err_abort;
    logic              r_err_ovf;
    entry_t            w_in;
    entry_t            w_head;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_pop;

    // Current address/word with the bit at position r_cnt replaced by din (LSB first).
    always_comb begin
        w_addr_set = r_addr;
        w_word_set = r_word;
        for (int i = 0; i < ADDR_W; i++) begin
            if (r_cnt == CNT_W'(i)) w_addr_set[i] = din;
        end
        for (int i = 0; i < DATA_W; i++) begin
            if (r_cnt == CNT_W'(i)) w_word_set[i] = din;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: frame_n high outside IDLE always returns to IDLE (end of packet or abort).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!frame_n) w_state_nxt = (ADDR_W > 1) ? ST_ADDR : AFTER_ADDR;
            ST_ADDR: begin
                if (frame_n)                 w_state_nxt = ST_IDLE;
                else if (r_cnt == ADDR_LAST) w_state_nxt = AFTER_ADDR;
            end
            ST_PAD: begin
                if (frame_n)                w_state_nxt = ST_IDLE;
                else if (r_cnt == PAD_LAST) w_state_nxt = ST_DATA;
            end
            ST_DATA: if (frame_n) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state datapath updates, push strobes and error events.
    always_comb begin
        w_push     = 1'b0;
        w_last     = 1'b0;
        w_partial  = 1'b0;
        w_abort    = 1'b0;
        w_cnt_nxt  = r_cnt;
        w_addr_nxt = r_addr;
        w_word_nxt = r_word;
        case (r_state)
            ST_IDLE: begin
                if (!frame_n) begin
                    w_addr_nxt = ADDR_W'(din);
                    w_word_nxt = '0;
                    w_cnt_nxt  = (ADDR_W > 1) ? CNT_W'(1) : '0;
                end
            end
            ST_ADDR: begin
                if (frame_n) begin
                    w_abort   = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_addr_nxt = w_addr_set;
                    w_cnt_nxt  = (r_cnt == ADDR_LAST) ? '0 : r_cnt + CNT_W'(1);
                end
            end
            ST_PAD: begin
                if (frame_n) begin
                    w_abort   = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = (r_cnt == PAD_LAST) ? '0 : r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (!valid_n) begin
                    if (frame_n || (r_cnt == DATA_LAST)) begin
                        // Unreceived upper bits are already zero since the word clears after each push.
                        w_push     = 1'b1;
                        w_last     = frame_n;
                        w_partial  = frame_n && (r_cnt != DATA_LAST);
                        w_word_nxt = '0;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_word_nxt = w_word_set;
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                    end
                end else if (frame_n) begin
                    w_abort    = 1'b1;
                    w_word_nxt = '0;
                    w_cnt_nxt  = '0;
                end
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    // Bit counter, address and word shift registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_word <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_addr <= w_addr_nxt;
            r_word <= w_word_nxt;
        end
    end

    assign w_in.data = w_word_set;
    assign w_in.addr = r_addr;
    assign w_in.last = w_last;
    assign w_pop     = !w_empty && out_ready;

    router_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_dat   (w_in),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Error pulses are registered so they line up with the pushed word appearing on out_*.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_partial <= 1'b0;
            r_err_abort   <= 1'b0;
            r_err_ovf     <= 1'b0;
        end else begin
            r_err_partial <= w_partial;
            r_err_abort   <= w_abort;
            r_err_ovf     <= w_push && w_full && !w_pop;
        end
    end

    assign busy_n      = (w_count != CW'(DEPTH));
    assign out_valid   = !w_empty;
    assign out_data    = w_head.data;
    assign out_addr    = w_head.addr;
    assign out_last    = w_head.last;
    assign err_partial = r_err_partial;
    assign err_abort   = r_err_abort;
    assign err_ovf     = r_err_ovf;

`ifdef ROUTER_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic [9:0] w_err_sum;

    assign w_err_sum = 10'(r_err_cnt) + 10'(r_err_partial) + 10'(r_err_abort) + 10'(r_err_ovf);

    // Saturating count of all error pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_err_cnt <= '0;
        else          r_err_cnt <= (w_err_sum > 10'd255) ? 8'hFF : w_err_sum[7:0];
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
